key_conditioner: RTL and testbench
==================================

# key_conditioner

Input-side conditioning stage for the calendar: synchronises and debounces the raw active-low push-buttons and emits one-cycle press pulses with optional hold-to-repeat. Also generates the 1 Hz and 4 Hz timebase strobes and the 2 Hz blink level. Its outputs feed the counter, date and display stages as single-cycle enables, so no downstream block sees bouncing or multi-cycle button levels.

## Interface
- CLK_HZ, 50_000_000: CLOCK_50 frequency.
- NKEYS, 3: number of push-buttons.
- DEBOUNCE_MS, 20: required stable time for a press or release.
- REPEAT_DELAY_MS, 500: hold time before the first auto-repeat.
- REPEAT_RATE_HZ, 8: auto-repeat pulse rate after the first repeat.

- CLOCK_50  in  1  single system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- key_n  in  NKEYS  raw buttons, active-low, asynchronous to CLOCK_50.
- press  out  NKEYS  one-cycle pulse per accepted press and per repeat.
- held  out  NKEYS  debounced pressed level.
- tick_4hz  out  1  one-cycle strobe every CLK_HZ/4 cycles.
- tick_1hz  out  1  one-cycle strobe, coincident with every 4th tick_4hz.
- blink  out  1  level that toggles on each tick_4hz (2 Hz square wave).

## Operation
- Derived constants (integer division): DB = CLK_HZ/1000*DEBOUNCE_MS; RD = CLK_HZ/1000*REPEAT_DELAY_MS; RP = CLK_HZ/REPEAT_RATE_HZ; Q = CLK_HZ/4.
- Counter widths: $clog2(max+1) of each constant. Every counter saturates or wraps only where stated below.
- Each key gets a 2-FF synchroniser followed by an inversion, producing s (1 = pressed).
- Per-key FSM:
  - IDLE: s=1 → DB_PRESS, debounce counter cleared.
  - DB_PRESS: s=0 → IDLE. Counter reaches DB-1 with s=1 → PRESSED; press pulses in that cycle; held rises in the next cycle.
  - PRESSED: s=0 → DB_REL. Repeat counter reaches RD-1 → REPEAT, with a press pulse.
  - REPEAT: a press pulse every RP cycles. s=0 → DB_REL.
  - DB_REL: s=1 → back to the originating PRESSED or REPEAT state. The repeat counter is frozen during DB_REL and not cleared. Counter reaches DB-1 with s=0 → IDLE; held falls.
- Keys are fully independent. Simultaneous presses give simultaneous pulses.
- Timebase:
  - The divider counts 0..Q-1 and pulses tick_4hz at Q-1.
  - A 2-bit quarter counter increments on each tick_4hz; tick_1hz pulses when the quarter counter is 3 and tick_4hz is high.
  - blink toggles on each tick_4hz.

## Timing
- Reset values: all outputs 0, all FSMs IDLE, all counters 0.
- Press latency: the first press pulse comes 2 (sync) + DB cycles after key_n falls and stays stable.
- Release latency: held falls 2 + DB + 1 cycles after key_n rises and stays stable.
- Bounces shorter than DB cycles produce no pulse and no held change.
- Reset asserted mid-press: the FSM goes to IDLE at once. If the key is still down after reset deasserts, it is re-debounced and exactly one new press is generated.
- The first tick_4hz occurs Q cycles after reset deasserts; the first tick_1hz occurs 4Q cycles after reset deasserts.

## Configuration
- KEY_AUTOREPEAT_EN:
  - Defined: PRESSED/REPEAT behaviour as above.
  - Undefined: the REPEAT state and repeat counter are compiled out, PRESSED waits only for release, and exactly one press pulse is produced per physical press regardless of hold time.

## Structure
- Package calendar_input_pkg holds:
  - the key FSM state enum (IDLE, DB_PRESS, PRESSED, REPEAT, DB_REL);
  - the constant functions ms_to_cycles and hz_to_cycles.
- Sub-module key_channel holds the synchroniser, FSM and counters for one key. It is instantiated NKEYS times via generate.
- The timebase stays in the top module.

## Test plan
All scenarios use CLK_HZ=1000, DEBOUNCE_MS=5, REPEAT_DELAY_MS=20, REPEAT_RATE_HZ=100, which gives DB=5, RD=20, RP=10, Q=250.
- Clean press: key_n[0] held low 3 cycles after reset → press[0] pulses once at cycle 7 after the falling edge; held[0]=1 from cycle 8.
- Bounce: key_n[1] low for 3 cycles, high for 2, low for 3, then high → no press[1] pulse; held[1] stays 0.
- Auto-repeat (macro defined): key_n[2] held low for 60 cycles → pulses at +7, +27, +37, +47, +57 relative to the falling edge. With the macro undefined → only the +7 pulse.
- Release glitch: during hold, a 2-cycle high glitch → held stays 1, no extra pulse, repeat phase shifted by 2 cycles.
- Timebase: run 1000 cycles from reset → tick_4hz at cycles 250, 500, 750 and 1000; tick_1hz only at cycle 1000; blink = 1, 0, 1, 0 after each tick.
- Reset mid-hold: assert reset during REPEAT with the key still low → held=0 and press=0 immediately; after release of reset, one press pulse at +7 cycles.

Source files
------------

// File: rtl/calendar_input_pkg.sv
// -----------------------------------------------------------------------------
// calendar_input_pkg
//   Shared types and constant helpers for the calendar input stage.
//   - key_state_t  : per-key debounce / auto-repeat FSM states
//   - ms_to_cycles : milliseconds -> clock cycles (integer division first)
//   - hz_to_cycles : rate in Hz -> period in clock cycles
//   - cnt_width    : bits needed to hold the value max_val
// -----------------------------------------------------------------------------
package calendar_input_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    PRESSED  = 3'd2,
    REPEAT   = 3'd3,
    DB_REL   = 3'd4
  } key_state_t;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

  function automatic int hz_to_cycles(input int clk_hz, input int hz);
    return clk_hz / hz;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// -----------------------------------------------------------------------------
// key_channel
//   One push-button: 2-FF synchroniser, debounce FSM and (optionally) the
//   hold-to-repeat counter. Emits a one-cycle press pulse per accepted press
//   (and per repeat) plus the debounced pressed level.
//
//   Optional feature macro: KEY_AUTOREPEAT_EN (adds REPEAT state and counter).
//
//   Ports
//     clk    in   system clock, rising edge
//     rst    in   asynchronous, active-high reset
//     key_n  in   raw button, active-low, asynchronous to clk
//     press  out  one-cycle pulse per accepted press / repeat
//     held   out  debounced pressed level
// -----------------------------------------------------------------------------
module key_channel
  import calendar_input_pkg::*;
#(
  parameter int DB = 5
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int RD = 20,
  parameter int RP = 10
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press,
  output logic held
);

  localparam int DB_W = cnt_width(DB);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB - 1);
`ifdef KEY_AUTOREPEAT_EN
  // One counter serves both the initial delay and the repeat period.
  localparam int RC_W = cnt_width((RD > RP) ? RD : RP);
  localparam logic [RC_W-1:0] RD_LAST = RC_W'(RD - 1);
  localparam logic [RC_W-1:0] RP_LAST = RC_W'(RP - 1);
`endif

  // Synchroniser resets to "released" so reset release never looks like a press.
  logic [1:0] sync_q;
  logic       s;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, giving a true two-stage delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], key_n};
  end

  assign s = ~sync_q[1];

  key_state_t      state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
`ifdef KEY_AUTOREPEAT_EN
  logic [RC_W-1:0] rep_cnt_q, rep_cnt_d;
  logic            from_rep_q, from_rep_d;  // DB_REL returns to REPEAT when set
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      db_cnt_q   <= '0;
`ifdef KEY_AUTOREPEAT_EN
      rep_cnt_q  <= '0;
      from_rep_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
`ifdef KEY_AUTOREPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
      from_rep_q <= from_rep_d;
`endif
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    press      = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    rep_cnt_d  = rep_cnt_q;
    from_rep_d = from_rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d  = DB_PRESS;
          db_cnt_d = '0;
        end
      end

      DB_PRESS: begin
        if (!s) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          press   = 1'b1;
          state_d = PRESSED;
`ifdef KEY_AUTOREPEAT_EN
          rep_cnt_d = '0;
`endif
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end

`ifdef KEY_AUTOREPEAT_EN
      // The repeat counter keeps running on the cycle release is first seen,
      // so a short glitch delays the repeat phase only by its DB_REL cycles.
      // At a terminal count with the key up, the count is held and the pulse
      // is issued on return if the key is down again.
      PRESSED, REPEAT: begin
        if (rep_cnt_q == ((state_q == PRESSED) ? RD_LAST : RP_LAST)) begin
          if (s) begin
            press     = 1'b1;
            state_d   = REPEAT;
            rep_cnt_d = '0;
          end
        end else begin
          rep_cnt_d = rep_cnt_q + RC_W'(1);
        end
        if (!s) begin
          state_d    = DB_REL;
          db_cnt_d   = '0;
          from_rep_d = (state_q == REPEAT);
        end
      end
`else
      PRESSED: begin
        if (!s) begin
          state_d  = DB_REL;
          db_cnt_d = '0;
        end
      end
`endif

      DB_REL: begin
        if (s) begin
`ifdef KEY_AUTOREPEAT_EN
          state_d = from_rep_q ? REPEAT : PRESSED;
`else
          state_d = PRESSED;
`endif
        end else if (db_cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign held = (state_q == PRESSED) || (state_q == REPEAT) || (state_q == DB_REL);

endmodule

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//   Input conditioning for the calendar: debounced one-cycle press pulses per
//   push-button (with optional hold-to-repeat) and the 4 Hz / 1 Hz timebase
//   strobes plus the 2 Hz blink level.
//
//   Optional feature macro: KEY_AUTOREPEAT_EN (hold-to-repeat on every key).
//
//   Ports
//     CLOCK_50  in   system clock, rising edge
//     reset     in   asynchronous, active-high reset
//     key_n     in   [NKEYS] raw buttons, active-low
//     press     out  [NKEYS] one-cycle pulse per press / repeat
//     held      out  [NKEYS] debounced pressed level
//     tick_4hz  out  one-cycle strobe every CLK_HZ/4 cycles
//     tick_1hz  out  one-cycle strobe on every 4th tick_4hz
//     blink     out  toggles on each tick_4hz (2 Hz square wave)
// -----------------------------------------------------------------------------
module key_conditioner
  import calendar_input_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int NKEYS           = 3,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_HZ  = 8
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_n,
  output logic [NKEYS-1:0] press,
  output logic [NKEYS-1:0] held,
  output logic             tick_4hz,
  output logic             tick_1hz,
  output logic             blink
);

  localparam int DB = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
`ifdef KEY_AUTOREPEAT_EN
  localparam int RD = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
  localparam int RP = hz_to_cycles(CLK_HZ, REPEAT_RATE_HZ);
`else
  // Repeat timing has no effect without auto-repeat; it is folded into a
  // deliberately unused constant so the parameter list stays identical.
  localparam int unused_repeat_cfg = REPEAT_DELAY_MS + REPEAT_RATE_HZ;
`endif
  localparam int Q = hz_to_cycles(CLK_HZ, 4);
  localparam int Q_W = cnt_width(Q);
  localparam logic [Q_W-1:0] Q_LAST = Q_W'(Q - 1);

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    key_channel #(
      .DB(DB)
`ifdef KEY_AUTOREPEAT_EN
      ,
      .RD(RD),
      .RP(RP)
`endif
    ) u_channel (
      .clk  (CLOCK_50),
      .rst  (reset),
      .key_n(key_n[k]),
      .press(press[k]),
      .held (held[k])
    );
  end

  // Timebase: tick_4hz and blink are registered from the terminal count, so
  // both change on the edge that ends divider cycle Q-1.
  logic [Q_W-1:0] div_q;
  logic [1:0]     quarter_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      quarter_q <= '0;
      tick_4hz  <= 1'b0;
      blink     <= 1'b0;
    end else begin
      if (div_q == Q_LAST) begin
        div_q <= '0;
        blink <= ~blink;
      end else begin
        div_q <= div_q + Q_W'(1);
      end
      tick_4hz <= (div_q == Q_LAST);
      if (tick_4hz) quarter_q <= quarter_q + 2'd1;
    end
  end

  assign tick_1hz = tick_4hz && (quarter_q == 2'd3);

endmodule

// File: tb/tb_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_conditioner
//   Self-checking bench for key_conditioner at CLK_HZ=1000 (DB=5, RD=20,
//   RP=10, Q=250). Outputs are sampled on the falling clock edge; inputs are
//   driven there too. Honours KEY_AUTOREPEAT_EN for repeat expectations.
// -----------------------------------------------------------------------------
module tb_key_conditioner;

  localparam int CLK_HZ          = 1000;
  localparam int NK              = 3;
  localparam int DEBOUNCE_MS     = 5;
  localparam int REPEAT_DELAY_MS = 20;
  localparam int REPEAT_RATE_HZ  = 100;
  localparam int DB = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int RD = CLK_HZ / 1000 * REPEAT_DELAY_MS;
  localparam int RP = CLK_HZ / REPEAT_RATE_HZ;
  localparam int Q  = CLK_HZ / 4;

  logic          CLOCK_50 = 1'b0;
  logic          reset    = 1'b1;
  logic [NK-1:0] key_n    = '1;
  logic [NK-1:0] press, held;
  logic          tick_4hz, tick_1hz, blink;

  always #5 CLOCK_50 = ~CLOCK_50;

  key_conditioner #(
    .CLK_HZ         (CLK_HZ),
    .NKEYS          (NK),
    .DEBOUNCE_MS    (DEBOUNCE_MS),
    .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
    .REPEAT_RATE_HZ (REPEAT_RATE_HZ)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .key_n   (key_n),
    .press   (press),
    .held    (held),
    .tick_4hz(tick_4hz),
    .tick_1hz(tick_1hz),
    .blink   (blink)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // cycles since reset release, as seen at the sample point

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A key is accepted once its synchronised level has been stable for DB+1
  // sampled cycles; release likewise. Repeats are scheduled on "elapsed held
  // time", which excludes cycles spent re-debouncing a release.
  logic [NK-1:0] kp1, kp2;            // key_n applied one and two cycles ago
  bit            m_db   [NK];         // debounced pressed
  bit            m_sprev[NK];
  int            m_run  [NK];         // length of current constant run of s
  int            m_el   [NK];         // elapsed held time for repeat timing

`ifdef KEY_AUTOREPEAT_EN
  function automatic bit repeat_due(input int e);
    return (e == RD - 1) || ((e > RD - 1) && ((e - (RD - 1)) % RP == 0));
  endfunction
`endif

  task automatic model_reset();
    kp1 = '1;
    kp2 = '1;
    for (int k = 0; k < NK; k++) begin
      m_db[k] = 0; m_sprev[k] = 0; m_run[k] = 1; m_el[k] = 0;
    end
  endtask

  int watch = 0;
  int plog[$];

  // Apply kn for the current cycle, advance one cycle, compare everything.
  task automatic step(input logic [NK-1:0] kn);
    logic [NK-1:0] exp_press, exp_held;
    key_n = kn;
    kp2 = kp1;
    kp1 = kn;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    cyc++;
    exp_press = '0;
    exp_held  = '0;
    for (int k = 0; k < NK; k++) begin
      bit s, nd;
      s = ~kp2[k];
      if (s == m_sprev[k]) m_run[k] = (m_run[k] < 100000) ? m_run[k] + 1 : m_run[k];
      else                 m_run[k] = 1;
      exp_held[k] = m_db[k];
      nd = m_db[k];
      if (!m_db[k]) begin
        if (s && m_run[k] == DB + 1) begin
          exp_press[k] = 1'b1;
          nd = 1;
          m_el[k] = 0;
        end
      end else if (!m_sprev[k]) begin
        if (!s && m_run[k] == DB + 1) nd = 0;
      end else begin
`ifdef KEY_AUTOREPEAT_EN
        if (repeat_due(m_el[k])) begin
          if (s) begin
            exp_press[k] = 1'b1;
            m_el[k]++;
          end
        end else begin
          m_el[k]++;
        end
`endif
      end
      m_sprev[k] = s;
      m_db[k]    = nd;
    end
    check("press", press, exp_press);
    check("held", held, exp_held);
    check("tick_4hz", tick_4hz, (cyc % Q == 0) ? 1 : 0);
    check("tick_1hz", tick_1hz, (cyc % (4 * Q) == 0) ? 1 : 0);
    check("blink", blink, (cyc / Q) % 2);
    if (press[watch]) plog.push_back(cyc);
  endtask

  task automatic hold(input logic [NK-1:0] kn, input int n);
    for (int i = 0; i < n; i++) step(kn);
  endtask

  task automatic do_reset(input logic [NK-1:0] kn);
    reset = 1'b1;
    key_n = kn;
    #1;
    check("reset_press", press, 0);
    check("reset_held", held, 0);
    check("reset_tick_4hz", tick_4hz, 0);
    check("reset_tick_1hz", tick_1hz, 0);
    check("reset_blink", blink, 0);
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    cyc = 0;
    model_reset();
    check("cycle0_outputs", {press, held, tick_4hz, tick_1hz, blink}, 0);
  endtask

  task automatic check_pulses(input string name, input int t0, input int exp_q[$]);
    check({name, "_count"}, plog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < plog.size(); i++)
      check({name, "_offset"}, plog[i] - t0, exp_q[i]);
  endtask

  typedef struct {
    int   cyc;
    logic t4;
    logic t1;
    logic bl;
  } tb_vec_t;

  tb_vec_t tb_vec[12];

  initial begin
    int t0;
    int exp_q[$];
    logic [NK-1:0] lvl;
    int dur[NK];

    tb_vec[0]  = '{0,    1'b0, 1'b0, 1'b0};
    tb_vec[1]  = '{249,  1'b0, 1'b0, 1'b0};
    tb_vec[2]  = '{250,  1'b1, 1'b0, 1'b1};
    tb_vec[3]  = '{251,  1'b0, 1'b0, 1'b1};
    tb_vec[4]  = '{499,  1'b0, 1'b0, 1'b1};
    tb_vec[5]  = '{500,  1'b1, 1'b0, 1'b0};
    tb_vec[6]  = '{501,  1'b0, 1'b0, 1'b0};
    tb_vec[7]  = '{750,  1'b1, 1'b0, 1'b1};
    tb_vec[8]  = '{999,  1'b0, 1'b0, 1'b1};
    tb_vec[9]  = '{1000, 1'b1, 1'b1, 1'b0};
    tb_vec[10] = '{1001, 1'b0, 1'b0, 1'b0};
    tb_vec[11] = '{1250, 1'b1, 1'b0, 1'b1};

    // Timebase from reset, table driven.
    do_reset('1);
    for (int i = 0; i < 12; i++) begin
      while (cyc < tb_vec[i].cyc) step('1);
      check("tb_tick_4hz", tick_4hz, tb_vec[i].t4);
      check("tb_tick_1hz", tick_1hz, tb_vec[i].t1);
      check("tb_blink", blink, tb_vec[i].bl);
    end

    // Clean press on key 0, three cycles after reset.
    do_reset('1);
    hold('1, 3);
    watch = 0; plog.delete(); t0 = cyc;
    hold(3'b110, 7);
    check("clean_press_pulse", press[0], 1);
    check("clean_held_before", held[0], 0);
    step(3'b110);
    check("clean_held_after", held[0], 1);
    check("clean_press_single", press[0], 0);
    hold(3'b110, 6);
    exp_q = {7};
    check_pulses("clean", t0, exp_q);
    // Release latency: held drops 2 + DB + 1 cycles after key_n rises.
    hold('1, 2 + DB);
    check("release_held_still", held[0], 1);
    step('1);
    check("release_held_fall", held[0], 0);
    hold('1, 5);

    // Bounce on key 1: no pulse, held stays low.
    watch = 1; plog.delete(); t0 = cyc;
    hold(3'b101, 3);
    hold(3'b111, 2);
    hold(3'b101, 3);
    hold(3'b111, 20);
    exp_q = {};
    check_pulses("bounce", t0, exp_q);
    check("bounce_held", held[1], 0);

    // Simultaneous press on all keys.
    hold(3'b000, 7);
    check("simul_press", press, 3'b111);
    hold(3'b000, 3);
    hold(3'b111, 12);

    // Long hold on key 2.
    watch = 2; plog.delete(); t0 = cyc;
    hold(3'b011, 60);
    hold(3'b111, 15);
`ifdef KEY_AUTOREPEAT_EN
    exp_q = {7, 27, 37, 47, 57};
`else
    exp_q = {7};
`endif
    check_pulses("repeat", t0, exp_q);

    // Two-cycle release glitch during hold: phase slips by two cycles.
    plog.delete(); t0 = cyc;
    hold(3'b011, 30);
    hold(3'b111, 2);
    hold(3'b011, 38);
    check("glitch_held", held[2], 1);
    hold(3'b111, 15);
`ifdef KEY_AUTOREPEAT_EN
    exp_q = {7, 27, 39, 49, 59, 69};
`else
    exp_q = {7};
`endif
    check_pulses("glitch", t0, exp_q);

    // Reset while holding key 2; key stays down across reset.
    hold(3'b011, 35);
    check("pre_reset_held", held[2], 1);
    do_reset(3'b011);
    plog.delete(); t0 = cyc;
    hold(3'b011, 20);
    exp_q = {7};
    check_pulses("reset_hold", t0, exp_q);
    hold(3'b111, 12);

    // Randomised independent key activity with bounces and long holds.
    lvl = '1;
    for (int k = 0; k < NK; k++) dur[k] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NK; k++) begin
        if (dur[k] == 0) begin
          lvl[k] = ~lvl[k];
          dur[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DB)
                                               : $urandom_range(DB + 1, 45);
        end
        dur[k]--;
      end
      if (i == 1500) do_reset(lvl);
      step(lvl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
